// File: rtl/simd_loop_sequencer.sv
// Loop sequencer between SIMD fetch and decode/AGU: captures a LOOP body, replays it with in_single_loop, then drains.
// Optional SIMD_LOOP_STATS_EN adds stat_issued/stat_loops counters; 1-cycle latency, stalls on out_ready low.
module simd_loop_sequencer #(
  parameter int                     OPCODE_BITS   = 4,
  parameter int                     FUNCTION_BITS = 4,
  parameter int                     INST_WIDTH    = 32,
  parameter logic [OPCODE_BITS-1:0] LOOP_OPCODE   = 4'b1001,
  parameter int                     BODY_DEPTH    = 8,
  parameter int                     ITER_WIDTH    = 16,
  parameter int                     DRAIN_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_in_single_loop,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] loop_iter,
  output logic                  body_overflow
`ifdef SIMD_LOOP_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [15:0]           stat_loops
`endif
);

  localparam int PW = (BODY_DEPTH > 1) ? $clog2(BODY_DEPTH) : 1;
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPLAY  = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
  logic                  single_q, single_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         lidx_q, lidx_d;
  logic [ITER_WIDTH-1:0] cnt_last_q, cnt_last_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  ovf_q, ovf_d;
  logic                  body_we;
  logic [INST_WIDTH-1:0] body_q [BODY_DEPTH];

  logic                     adv;
  logic [OPCODE_BITS-1:0]   opcode;
  logic [FUNCTION_BITS-1:0] fn;
  logic [ITER_WIDTH-1:0]    iter_field;
  logic                     is_loop;
  logic                     fn_over;
  logic [PW-1:0]            lidx_new;
  logic [ITER_WIDTH-1:0]    cnt_new;

  assign adv        = ~out_valid_q | out_ready;
  assign opcode     = in_inst[INST_WIDTH-1 -: OPCODE_BITS];
  assign fn         = in_inst[INST_WIDTH-OPCODE_BITS-1 -: FUNCTION_BITS];
  assign iter_field = in_inst[ITER_WIDTH-1:0];
  assign is_loop    = (opcode == LOOP_OPCODE);
  // Body length fn+1 is clamped to the buffer; we keep the last index (L-1).
  assign fn_over    = (32'(fn) >= 32'(BODY_DEPTH));
  assign lidx_new   = fn_over ? PW'(BODY_DEPTH - 1) : fn[PW-1:0];
  assign cnt_new    = (iter_field == '0) ? '0 : iter_field - ITER_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    single_d    = single_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    lidx_d      = lidx_q;
    cnt_last_d  = cnt_last_q;
    iter_d      = iter_q;
    drain_d     = drain_q;
    ovf_d       = ovf_q;
    body_we     = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = adv;
        if (adv) begin
          out_valid_d = 1'b0;
          single_d    = 1'b0;
          if (in_valid) begin
            if (is_loop) begin
              lidx_d     = lidx_new;
              cnt_last_d = cnt_new;
              ovf_d      = ovf_q | fn_over;
              wptr_d     = '0;
              iter_d     = '0;
              state_d    = S_CAPTURE;
            end else begin
              out_valid_d = 1'b1;
              out_inst_d  = in_inst;
            end
          end
        end
      end

      S_CAPTURE: begin
        in_ready = adv;
        if (adv) begin
          out_valid_d = 1'b0;
          single_d    = 1'b0;
          if (in_valid) begin
            body_we     = 1'b1;
            out_valid_d = 1'b1;
            out_inst_d  = in_inst;
            if (wptr_q == lidx_q) begin
              if (cnt_last_q == '0) begin
                state_d = S_DRAIN;
                drain_d = DW'(DRAIN_CYCLES);
              end else begin
                state_d = S_REPLAY;
                rptr_d  = '0;
                iter_d  = ITER_WIDTH'(1);
              end
            end else begin
              wptr_d = wptr_q + PW'(1);
            end
          end
        end
      end

      S_REPLAY: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_inst_d  = body_q[rptr_q];
          single_d    = 1'b1;
          if (rptr_q == lidx_q) begin
            rptr_d = '0;
            if (iter_q == cnt_last_q) begin
              state_d = S_DRAIN;
              drain_d = DW'(DRAIN_CYCLES);
            end else begin
              iter_d = iter_q + ITER_WIDTH'(1);
            end
          end else begin
            rptr_d = rptr_q + PW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (adv) begin
          out_valid_d = 1'b0;
          single_d    = 1'b0;
        end
        // Idle window only counts once the final loop instruction has left.
        if (!out_valid_q) begin
          if (drain_q <= DW'(1)) begin
            state_d = S_IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      single_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      lidx_q      <= '0;
      cnt_last_q  <= '0;
      iter_q      <= '0;
      drain_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      single_q    <= single_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      lidx_q      <= lidx_d;
      cnt_last_q  <= cnt_last_d;
      iter_q      <= iter_d;
      drain_q     <= drain_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (body_we) begin
      body_q[wptr_q] <= in_inst;
    end
  end

  assign out_valid          = out_valid_q;
  assign out_inst           = out_inst_q;
  assign out_in_single_loop = single_q;
  assign busy               = (state_q != S_IDLE);
  assign loop_iter          = iter_q;
  assign body_overflow      = ovf_q;

`ifdef SIMD_LOOP_STATS_EN
  logic [31:0] stat_issued_q;
  logic [15:0] stat_loops_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_loops_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if (state_q == S_DRAIN && state_d == S_IDLE) begin
        stat_loops_q <= stat_loops_q + 16'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_loops  = stat_loops_q;
`endif

endmodule

// File: tb/tb_simd_loop_sequencer.sv
// Directed bench for simd_loop_sequencer: pass-through, loops, C=0/1, overflow, backpressure, reset mid-loop.
module tb_simd_loop_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic        out_in_single_loop;
  logic        busy;
  logic [15:0] loop_iter;
  logic        body_overflow;
`ifdef SIMD_LOOP_STATS_EN
  logic [31:0] stat_issued;
  logic [15:0] stat_loops;
`endif

  int checks = 0;
  int errors = 0;

  simd_loop_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_inst            (in_inst),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_inst           (out_inst),
    .out_in_single_loop (out_in_single_loop),
    .out_ready          (out_ready),
    .busy               (busy),
    .loop_iter          (loop_iter),
    .body_overflow      (body_overflow)
`ifdef SIMD_LOOP_STATS_EN
    ,
    .stat_issued        (stat_issued),
    .stat_loops         (stat_loops)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_loop(input logic [3:0] fn, input logic [15:0] c);
    return {4'b1001, fn, 8'h00, c};
  endfunction

  function automatic logic [31:0] mk_op(input logic [7:0] tag);
    return {4'h2, 4'h5, 16'h1234, tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_in_single_loop, busy, body_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got v=%0b f=%0b busy=%0b ovf=%0b exp all 0",
               out_valid, out_in_single_loop, busy, body_overflow);
    end
    checks++;
    if (out_inst !== 32'h0) begin
      errors++; $display("FAIL reset_inst got %h exp 0", out_inst);
    end
    checks++;
    if (loop_iter !== 16'd0) begin
      errors++; $display("FAIL reset_iter got %0d exp 0", loop_iter);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w = mk_op(8'h10 + 8'(k));
      in_valid = 1'b1; in_inst = w;
      tick();
      checks++;
      if ({out_valid, out_in_single_loop, busy, out_inst} !== {3'b100, w}) begin
        errors++;
        $display("FAIL pt_out%0d got v=%0b f=%0b busy=%0b inst=%h exp v=1 f=0 busy=0 inst=%h",
                 k, out_valid, out_in_single_loop, busy, out_inst, w);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pt_idle got v=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_basic_loop();
    logic [31:0] a, b, j;
    logic [31:0] ex_inst [4];
    logic [15:0] ex_li [4];
    logic [15:0] li;
    a = mk_op(8'hA0); b = mk_op(8'hB0); j = mk_op(8'hEE);
    ex_inst[0] = a; ex_inst[1] = b; ex_inst[2] = a; ex_inst[3] = b;
    ex_li[0] = 16'd1; ex_li[1] = 16'd1; ex_li[2] = 16'd2; ex_li[3] = 16'd2;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = mk_loop(4'd1, 16'd3);
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL bl_loop_consumed got v=%0b busy=%0b exp v=0 busy=1", out_valid, busy);
    end
    in_inst = a;
    tick();
    checks++;
    if ({out_valid, out_in_single_loop, out_inst} !== {2'b10, a}) begin
      errors++; $display("FAIL bl_cap_a got v=%0b f=%0b %h exp v=1 f=0 %h", out_valid, out_in_single_loop, out_inst, a);
    end
    in_inst = b;
    tick();
    checks++;
    if ({out_valid, out_in_single_loop, out_inst} !== {2'b10, b}) begin
      errors++; $display("FAIL bl_cap_b got v=%0b f=%0b %h exp v=1 f=0 %h", out_valid, out_in_single_loop, out_inst, b);
    end
    in_inst = j;
    for (int k = 0; k < 4; k++) begin
      li = loop_iter;
      tick();
      checks++;
      if ({out_valid, out_in_single_loop, out_inst} !== {2'b11, ex_inst[k]}) begin
        errors++;
        $display("FAIL bl_rep%0d got v=%0b f=%0b %h exp v=1 f=1 %h", k, out_valid, out_in_single_loop, out_inst, ex_inst[k]);
      end
      checks++;
      if (li !== ex_li[k]) begin
        errors++; $display("FAIL bl_iter%0d got %0d exp %0d", k, li, ex_li[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b001) begin
        errors++;
        $display("FAIL bl_drain%0d got v=%0b rdy=%0b busy=%0b exp v=0 rdy=0 busy=1", k, out_valid, in_ready, busy);
      end
    end
    tick();
    checks++;
    if ({busy, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bl_idle got busy=%0b rdy=%0b exp busy=0 rdy=1", busy, in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_in_single_loop, out_inst} !== {2'b10, j}) begin
      errors++; $display("FAIL bl_after got v=%0b f=%0b %h exp v=1 f=0 %h", out_valid, out_in_single_loop, out_inst, j);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_c0_c1();
    logic [31:0] x;
    int extra;
    for (int v = 0; v < 2; v++) begin
      x = mk_op(8'h40 + 8'(v));
      in_valid = 1'b1; in_inst = mk_loop(4'd0, 16'(v));
      tick();
      in_inst = x;
      tick();
      checks++;
      if ({out_valid, out_in_single_loop, busy, out_inst} !== {3'b101, x}) begin
        errors++;
        $display("FAIL c%0d_cap got v=%0b f=%0b busy=%0b %h exp v=1 f=0 busy=1 %h",
                 v, out_valid, out_in_single_loop, busy, out_inst, x);
      end
      in_valid = 1'b0;
      extra = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (out_valid) extra++;
      end
      checks++;
      if (extra !== 0) begin
        errors++; $display("FAIL c%0d_noreplay got %0d extra outputs exp 0", v, extra);
      end
      checks++;
      if ({busy, loop_iter} !== {1'b0, 16'd0}) begin
        errors++; $display("FAIL c%0d_end got busy=%0b iter=%0d exp busy=0 iter=0", v, busy, loop_iter);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [3];
    logic [31:0] ex [6];
    logic        exf [6];
    logic [31:0] lg_inst [$];
    logic        lg_flag [$];
    logic [19:0] pat;
    logic [31:0] p_inst;
    logic        p_flag, p_stall, acc;
    logic [15:0] p_iter;
    int idx, hold_bad, stalls;
    seq[0] = mk_loop(4'd1, 16'd3); seq[1] = mk_op(8'hA1); seq[2] = mk_op(8'hB1);
    for (int k = 0; k < 6; k++) begin
      ex[k]  = (k % 2 == 0) ? seq[1] : seq[2];
      exf[k] = (k >= 2);
    end
    pat = 20'b1111_1111_1110_1100_1111;
    idx = 0; hold_bad = 0; stalls = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (idx < 3);
      in_inst   = (idx < 3) ? seq[idx] : 32'h0;
      out_ready = pat[c];
      #1;
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        lg_inst.push_back(out_inst);
        lg_flag.push_back(out_in_single_loop);
      end
      p_stall = out_valid & ~out_ready;
      p_inst = out_inst; p_flag = out_in_single_loop; p_iter = loop_iter;
      if (p_stall) stalls++;
      tick();
      if (acc) idx++;
      if (p_stall && ({out_valid, out_in_single_loop, out_inst, loop_iter} !== {1'b1, p_flag, p_inst, p_iter}))
        hold_bad++;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    checks++;
    if (lg_inst.size() !== 6) begin
      errors++; $display("FAIL bp_count got %0d transfers exp 6", lg_inst.size());
    end
    for (int k = 0; k < 6 && k < lg_inst.size(); k++) begin
      checks++;
      if ({lg_flag[k], lg_inst[k]} !== {exf[k], ex[k]}) begin
        errors++; $display("FAIL bp_xfer%0d got f=%0b %h exp f=%0b %h", k, lg_flag[k], lg_inst[k], exf[k], ex[k]);
      end
    end
    checks++;
    if (stalls !== 3) begin
      errors++; $display("FAIL bp_stalls got %0d exp 3", stalls);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++; $display("FAIL bp_hold got %0d unstable stall cycles exp 0", hold_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bp_end got busy=%0b exp 0", busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [9];
    logic [31:0] lg_inst [$];
    logic        lg_flag [$];
    logic        lg_busy [$];
    logic        acc;
    int idx, bad;
    for (int k = 0; k < 9; k++) w[k] = mk_op(8'h60 + 8'(k));
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = mk_loop(4'd15, 16'd1);
    tick();
    checks++;
    if (body_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %0b exp 1", body_overflow);
    end
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 9);
      in_inst  = (idx < 9) ? w[idx] : 32'h0;
      #1;
      acc = in_valid & in_ready;
      if (out_valid) begin
        lg_inst.push_back(out_inst);
        lg_flag.push_back(out_in_single_loop);
        lg_busy.push_back(busy);
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (lg_inst.size() !== 9) begin
      errors++; $display("FAIL ovf_count got %0d exp 9", lg_inst.size());
    end
    bad = 0;
    for (int k = 0; k < 9 && k < lg_inst.size(); k++)
      if ({lg_flag[k], lg_inst[k]} !== {1'b0, w[k]}) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL ovf_data got %0d wrong words exp 0", bad);
    end
    if (lg_busy.size() == 9) begin
      checks++;
      if ({lg_busy[7], lg_busy[8]} !== 2'b10) begin
        errors++; $display("FAIL ovf_ninth got busy7=%0b busy8=%0b exp 1 0", lg_busy[7], lg_busy[8]);
      end
    end
    checks++;
    if (body_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %0b exp 1", body_overflow);
    end
  endtask

  task automatic test_reset_midloop();
    logic [31:0] p;
    int n;
    p = mk_op(8'hC7);
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = mk_loop(4'd1, 16'd4);
    tick();
    in_inst = mk_op(8'hA2); tick();
    in_inst = mk_op(8'hB2); tick();
    in_valid = 1'b0;
    n = 0;
    while (loop_iter != 16'd2 && n < 10) begin
      tick(); n++;
    end
    checks++;
    if ({busy, loop_iter} !== {1'b1, 16'd2}) begin
      errors++; $display("FAIL rm_reach got busy=%0b iter=%0d exp busy=1 iter=2", busy, loop_iter);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, in_ready, body_overflow} !== 4'b0010) begin
      errors++;
      $display("FAIL rm_abort got v=%0b busy=%0b rdy=%0b ovf=%0b exp v=0 busy=0 rdy=1 ovf=0",
               out_valid, busy, in_ready, body_overflow);
    end
    checks++;
    if (loop_iter !== 16'd0) begin
      errors++; $display("FAIL rm_iter got %0d exp 0", loop_iter);
    end
    reset = 1'b0;
    in_valid = 1'b1; in_inst = p;
    tick();
    checks++;
    if ({out_valid, out_in_single_loop, busy, out_inst} !== {3'b100, p}) begin
      errors++;
      $display("FAIL rm_pass got v=%0b f=%0b busy=%0b %h exp v=1 f=0 busy=0 %h",
               out_valid, out_in_single_loop, busy, out_inst, p);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic_loop();
    test_c0_c1();
    test_backpressure();
    test_overflow();
    test_reset_midloop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_loop_sequencer.md
# simd_loop_sequencer

Instruction-stream sequencer that sits between the SIMD instruction fetch and the iterator address generator and SIMD decode. It passes ordinary instructions through unchanged. On a LOOP instruction it captures the following loop body into a small buffer and issues it for the first iteration. It then replays the body for the remaining iterations with `in_single_loop` asserted, so the address generator applies base+stride writeback. A fixed drain window after each loop lets the address generator's 3-stage loop-delay pipeline retire before new instructions are accepted.

## Interface
- `OPCODE_BITS`, 4: opcode field width, at inst[INST_WIDTH-1 -: OPCODE_BITS].
- `FUNCTION_BITS`, 4: fn field width, directly below the opcode.
- `INST_WIDTH`, 32: instruction word width.
- `LOOP_OPCODE`, 4'b1001: opcode that marks a LOOP instruction.
- `BODY_DEPTH`, 8: body buffer entries; power of two, maximum 16.
- `ITER_WIDTH`, 16: iteration count width, taken from inst[ITER_WIDTH-1:0].
- `DRAIN_CYCLES`, 3: idle cycles after the last replayed instruction.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch presents an instruction.
- `in_inst` in INST_WIDTH: instruction word.
- `in_ready` out 1: sequencer accepts `in_inst` this cycle.
- `out_valid` out 1: registered instruction valid toward decode/AGU.
- `out_inst` out INST_WIDTH: registered instruction.
- `out_in_single_loop` out 1: qualifies `out_inst`; drives the AGU's `in_single_loop`.
- `out_ready` in 1: downstream consumes `out_inst`.
- `busy` out 1: state is not IDLE.
- `loop_iter` out ITER_WIDTH: iteration currently issuing, 0-based.
- `body_overflow` out 1: sticky; a LOOP requested more than BODY_DEPTH entries.

## Operation
- Transfers: input fires on `in_valid & in_ready`; output fires on `out_valid & out_ready`.
- `adv = ~out_valid | out_ready`.
- LOOP fields: body length L = fn+1, clamped to BODY_DEPTH. If fn+1 > BODY_DEPTH, set `body_overflow`. Count C = inst[ITER_WIDTH-1:0]; C=0 is treated as 1.
- The LOOP instruction itself is consumed and never appears on `out_inst`.
- IDLE:
  - `in_ready = adv`.
  - A non-LOOP instruction is forwarded with `out_in_single_loop=0`.
  - A LOOP instruction latches L and C, clears the write pointer and `loop_iter`, and moves to CAPTURE.
- CAPTURE:
  - `in_ready = adv`.
  - Each accepted instruction is written to `buf[wptr]` and forwarded with `out_in_single_loop=0` (iteration 0).
  - After the L-th instruction: go to DRAIN if C=1; otherwise go to REPLAY with rptr=0 and `loop_iter=1`.
- REPLAY:
  - `in_ready=0`.
  - On each `adv`, issue `buf[rptr]` with `out_in_single_loop=1`.
  - rptr wraps at L-1, and each wrap increments `loop_iter`.
  - After issuing entry L-1 with `loop_iter = C-1`, go to DRAIN.
- DRAIN:
  - `in_ready=0`. A down-counter loads DRAIN_CYCLES and starts once the last loop instruction has been accepted (`out_valid=0`).
  - At 0, return to IDLE.
- A LOOP instruction received during CAPTURE is treated as a body instruction (no nesting) and is forwarded unchanged.
- `out_inst`, `out_valid` and `out_in_single_loop` hold stable while `out_valid & ~out_ready`.

## Timing
- Pass-through latency is 1 cycle: accepted at edge N, visible on `out_*` after edge N.
- Throughput is 1 instruction per cycle in IDLE, CAPTURE and REPLAY while `out_ready=1`.
- The first replay instruction can issue in the cycle after the last capture transfer; there is no bubble.
- Loop of C iterations × L: the LOOP instruction costs 1 input cycle, followed by C·L output transfers and then DRAIN_CYCLES cycles in DRAIN.
- Reset values:
  - `out_valid=0`, `out_inst=0`, `out_in_single_loop=0`.
  - `busy=0`, `loop_iter=0`, `body_overflow=0`, state IDLE.
  - `in_ready=1`. This is combinational from state, so it is high in the first cycle after reset.
- Reset mid-loop aborts immediately. Buffer contents need not be cleared and are never reissued.
- `out_ready` low in REPLAY freezes rptr and `loop_iter`. `in_valid` is ignored while `in_ready=0`.

## Configuration
- `SIMD_LOOP_STATS_EN` defined: adds outputs `stat_issued` (32b, counts output transfers) and `stat_loops` (16b, counts DRAIN→IDLE transitions). Both reset to 0 and wrap on overflow.
- Not defined: neither port exists and no counter logic is built; all other behaviour is identical.

## Test plan
- Pass-through: 4 non-LOOP instructions, `out_ready=1` → the same 4 words appear 1 cycle later, `out_in_single_loop=0`, `busy=0`.
- Basic loop: LOOP with fn=1, C=3, then A,B → output A,B (flag 0), then A,B,A,B (flag 1); `loop_iter` 1,1,2,2; then 3 DRAIN cycles with `in_ready=0`; then IDLE.
- C=0 and C=1: LOOP fn=0 then X → X issued once with flag 0, no REPLAY, DRAIN then IDLE.
- Overflow: BODY_DEPTH=8, LOOP with fn=15 → `body_overflow=1` stays set, L=8, exactly 8 instructions captured; the 9th is forwarded as pass-through after DRAIN.
- Backpressure: `out_ready` toggling 1,0,0,1 during REPLAY → no duplicated or dropped entries; `out_inst` is held during stall cycles; total output transfers = C·L.
- Reset in REPLAY at `loop_iter=2` → next cycle `out_valid=0`, `busy=0`, `in_ready=1`; a following plain instruction passes through with flag 0.
